// File: rtl/jtcontra_gfx_rom_arb_if.sv
// Shared 007121 graphics ROM port bundle: two requesters (obj, scr), the SDRAM side and arbiter status.
// The slave modport is the arbiter's view; the master modport is the environment driving it.
interface jtcontra_gfx_rom_arb_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic          obj_cs;
    logic [AW-1:0] obj_addr;
    logic          obj_ok;
    logic [DW-1:0] obj_data;

    logic          scr_cs;
    logic [AW-1:0] scr_addr;
    logic          scr_ok;
    logic [DW-1:0] scr_data;

    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic          rom_ok;
    logic [DW-1:0] rom_data;

    logic [1:0]    owner;
    logic          wdog_err;

    modport slave (
        input  obj_cs, obj_addr, scr_cs, scr_addr, rom_ok, rom_data,
        output obj_ok, obj_data, scr_ok, scr_data, rom_cs, rom_addr, owner, wdog_err
    );

    modport master (
        output obj_cs, obj_addr, scr_cs, scr_addr, rom_ok, rom_data,
        input  obj_ok, obj_data, scr_ok, scr_data, rom_cs, rom_addr, owner, wdog_err
    );
endinterface

// File: rtl/jtcontra_gfx_rom_arb.sv
// Round-robin arbiter sharing one graphics SDRAM ROM port between the sprite (obj) and tile (scr) engines.
// Optional grant watchdog enabled by defining JTCONTRA_ROM_ARB_WDOG_EN.
module jtcontra_gfx_rom_arb #(
    parameter int AW      = 18,
    parameter int DW      = 16,
    parameter int OK_MASK = 1,
    parameter int WDOG    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    jtcontra_gfx_rom_arb_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OBJ  = 2'b01,
        ST_SCR  = 2'b10,
        ST_GAP  = 2'b11
    } state_e;

    localparam logic [1:0] MASK_LD = 2'(OK_MASK);

    state_e        state_q, state_d;
    logic          last_scr_q, last_scr_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [1:0]    mask_q, mask_d;
    logic          rom_cs_q, rom_cs_d;
    logic [1:0]    owner_q, owner_d;

    logic          granted;
    logic          own_cs;
    logic          oth_cs;
    logic [AW-1:0] own_addr;
    logic          own_ok;
    logic          wdog_hit;

    assign granted  = (state_q == ST_OBJ) || (state_q == ST_SCR);
    assign own_cs   = (state_q == ST_SCR) ? bus.scr_cs   : bus.obj_cs;
    assign oth_cs   = (state_q == ST_SCR) ? bus.obj_cs   : bus.scr_cs;
    assign own_addr = (state_q == ST_SCR) ? bus.scr_addr : bus.obj_addr;

    // Stale data from the previous address is rejected until the mask expires and the address matches.
    assign own_ok = granted && bus.rom_ok && (mask_q == 2'd0) && (own_addr == rom_addr_q);

    // NOTE: every variable assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        last_scr_d = last_scr_q;
        rom_addr_d = rom_addr_q;
        mask_d     = mask_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.obj_cs && (!bus.scr_cs || last_scr_q)) begin
                    state_d    = ST_OBJ;
                    rom_addr_d = bus.obj_addr;
                    mask_d     = MASK_LD;
                end else if (bus.scr_cs) begin
                    state_d    = ST_SCR;
                    rom_addr_d = bus.scr_addr;
                    mask_d     = MASK_LD;
                end
            end
            ST_OBJ, ST_SCR: begin
                rom_addr_d = own_addr;
                if (own_addr != rom_addr_q) begin
                    mask_d = MASK_LD;
                end else if (mask_q != 2'd0) begin
                    mask_d = mask_q - 2'd1;
                end
                if (!own_cs || (own_ok && oth_cs) || wdog_hit) begin
                    state_d    = ST_GAP;
                    last_scr_d = (state_q == ST_SCR);
                end
            end
            default: begin
                // The single GAP cycle gives the SDRAM a cs falling edge between owners.
                state_d = ST_IDLE;
            end
        endcase

        rom_cs_d = (state_d == ST_OBJ) || (state_d == ST_SCR);
        owner_d  = {state_d == ST_SCR, state_d == ST_OBJ};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_scr_q <= 1'b1;
            rom_addr_q <= '0;
            mask_q     <= 2'd0;
            rom_cs_q   <= 1'b0;
            owner_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_scr_q <= last_scr_d;
            rom_addr_q <= rom_addr_d;
            mask_q     <= mask_d;
            rom_cs_q   <= rom_cs_d;
            owner_q    <= owner_d;
        end
    end

`ifdef JTCONTRA_ROM_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          wdog_err_q;

    // Counts granted cycles without a delivered ok; the last counted cycle forces release.
    always_comb begin
        wdog_d   = '0;
        wdog_hit = 1'b0;
        if (granted && !own_ok) begin
            wdog_d   = wdog_q + 1'b1;
            wdog_hit = (wdog_q == WW'(WDOG - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_hit;
        end
    end

    assign bus.wdog_err = wdog_err_q;
`else
    logic unused_wdog;

    assign wdog_hit     = 1'b0;
    assign unused_wdog  = ^WDOG;
    assign bus.wdog_err = 1'b0;
`endif

    assign bus.rom_cs   = rom_cs_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.owner    = owner_q;
    assign bus.obj_ok   = (state_q == ST_OBJ) && own_ok;
    assign bus.scr_ok   = (state_q == ST_SCR) && own_ok;
    assign bus.obj_data = bus.rom_data;
    assign bus.scr_data = bus.rom_data;

endmodule

// File: tb/tb_jtcontra_gfx_rom_arb.sv
// Scoreboard bench for jtcontra_gfx_rom_arb: directed requests push expected oks, a negedge monitor pops them.
// Owner, rom_cs and rom_addr timing are checked inline against hand-derived cycle positions.
`timescale 1ns/1ps
module tb_jtcontra_gfx_rom_arb;
    localparam int AW      = 18;
    localparam int DW      = 16;
    localparam int OK_MASK = 1;
`ifdef JTCONTRA_ROM_ARB_WDOG_EN
    localparam int WDOG    = 16;
`else
    localparam int WDOG    = 255;
`endif
    localparam logic [1:0] W_OBJ = 2'b01;
    localparam logic [1:0] W_SCR = 2'b10;

    typedef struct packed {
        logic [1:0]    who;
        logic [DW-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    jtcontra_gfx_rom_arb_if #(.AW(AW), .DW(DW)) bus ();

    jtcontra_gfx_rom_arb #(
        .AW(AW), .DW(DW), .OK_MASK(OK_MASK), .WDOG(WDOG)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_ok(input logic [1:0] who, input logic [DW-1:0] data);
        exp_t e;
        e.who  = who;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic rom(input logic ok, input logic [DW-1:0] data);
        bus.rom_ok   = ok;
        bus.rom_data = data;
    endtask

    task automatic reset_dut();
        rst_n        = 1'b0;
        bus.obj_cs   = 1'b0;
        bus.obj_addr = '0;
        bus.scr_cs   = 1'b0;
        bus.scr_addr = '0;
        rom(1'b0, '0);
        #1;
        check("rst_rom_cs",   32'(bus.rom_cs),   32'h0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        check("rst_owner",    32'(bus.owner),    32'h0);
        check("rst_oks",      32'({bus.scr_ok, bus.obj_ok}), 32'h0);
        check("rst_wdog_err", 32'(bus.wdog_err), 32'h0);
        tick(2);
        rst_n = 1'b1;
    endtask

    // Monitor: every ok the DUT presents must match the oldest expected transfer.
    always @(negedge clk) begin
        if (rst_n && (bus.obj_ok || bus.scr_ok)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ok", 32'({bus.scr_ok, bus.obj_ok}), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_ok_owner", 32'({bus.scr_ok, bus.obj_ok}), 32'(e.who));
                check("sb_ok_data", 32'(bus.scr_ok ? bus.scr_data : bus.obj_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: single obj request, rom_ok three cycles after rom_cs.
        reset_dut();
        bus.obj_cs = 1'b1; bus.obj_addr = 18'h12345;
        at_neg(); check("t1_idle_rom_cs", 32'(bus.rom_cs), 32'h0);
        tick(); at_neg();
        check("t1_rom_cs",   32'(bus.rom_cs),   32'h1);
        check("t1_owner",    32'(bus.owner),    32'(W_OBJ));
        check("t1_rom_addr", 32'(bus.rom_addr), 32'h12345);
        tick(2);
        tick(); rom(1'b1, 16'hBEEF); expect_ok(W_OBJ, 16'hBEEF);
        at_neg();
        check("t1_obj_ok",   32'(bus.obj_ok),   32'h1);
        check("t1_wdog_err", 32'(bus.wdog_err), 32'h0);
        tick(); rom(1'b0, '0); bus.obj_cs = 1'b0;
        at_neg(); check("t1_hold_owner", 32'(bus.owner), 32'(W_OBJ));
        tick(); at_neg();
        check("t1_gap_rom_cs", 32'(bus.rom_cs), 32'h0);
        check("t1_gap_owner",  32'(bus.owner),  32'h0);
        tick();

        // Test 2: simultaneous requests after reset; obj first, gap, then scr.
        reset_dut();
        bus.obj_cs = 1'b1; bus.obj_addr = 18'h0AAAA;
        bus.scr_cs = 1'b1; bus.scr_addr = 18'h15555;
        tick(); at_neg();
        check("t2_first_owner", 32'(bus.owner),    32'(W_OBJ));
        check("t2_obj_addr",    32'(bus.rom_addr), 32'h0AAAA);
        tick(); rom(1'b1, 16'h1111); bus.obj_cs = 1'b0; expect_ok(W_OBJ, 16'h1111);
        at_neg(); check("t2_owner_c2", 32'(bus.owner), 32'(W_OBJ));
        tick(); rom(1'b0, '0);
        at_neg();
        check("t2_owner_gap",  32'(bus.owner),  32'h0);
        check("t2_rom_cs_gap", 32'(bus.rom_cs), 32'h0);
        tick(); at_neg(); check("t2_owner_idle", 32'(bus.owner), 32'h0);
        tick(); at_neg();
        check("t2_scr_owner", 32'(bus.owner),    32'(W_SCR));
        check("t2_scr_addr",  32'(bus.rom_addr), 32'h15555);
        check("t2_scr_cs",    32'(bus.rom_cs),   32'h1);
        tick(); rom(1'b1, 16'h2222); expect_ok(W_SCR, 16'h2222);
        tick(); rom(1'b0, '0); bus.scr_cs = 1'b0;
        tick(2);

        // Test 3: address change while rom_ok stays high is masked for one cycle.
        reset_dut();
        bus.obj_cs = 1'b1; bus.obj_addr = 18'h00010;
        tick();
        tick(); rom(1'b1, 16'hD010); expect_ok(W_OBJ, 16'hD010);
        tick(); bus.obj_addr = 18'h00011; bus.rom_data = 16'hD011;
        at_neg(); check("t3_ok_on_change", 32'(bus.obj_ok), 32'h0);
        tick(); at_neg();
        check("t3_rom_addr_new", 32'(bus.rom_addr), 32'h00011);
        check("t3_ok_masked",    32'(bus.obj_ok),   32'h0);
        tick(); expect_ok(W_OBJ, 16'hD011);
        at_neg(); check("t3_ok_after_mask", 32'(bus.obj_ok), 32'h1);
        tick(); rom(1'b0, '0); bus.obj_cs = 1'b0;
        tick(3);

        // Test 4: obj burst of 8; scr cuts in after one transfer and obj resumes after scr's ok.
        reset_dut();
        bus.obj_cs = 1'b1; bus.obj_addr = 18'h00100;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick(); rom(1'b1, 16'hA000 + 16'(i)); expect_ok(W_OBJ, 16'hA000 + 16'(i));
            at_neg(); check("t4_burst_owner", 32'(bus.owner), 32'(W_OBJ));
            tick(); rom(1'b0, '0);
            if (i < 7) bus.obj_addr = 18'h00100 + 18'(i + 1);
            else       bus.obj_cs = 1'b0;
            if (i == 2) begin
                bus.scr_cs = 1'b1; bus.scr_addr = 18'h002AB;
            end
            if (i == 3) begin
                at_neg(); check("t4_gap_rom_cs", 32'(bus.rom_cs), 32'h0);
                tick();
                tick(); at_neg();
                check("t4_scr_grant", 32'(bus.owner),    32'(W_SCR));
                check("t4_scr_addr",  32'(bus.rom_addr), 32'h002AB);
                tick(); rom(1'b1, 16'h5CA5); bus.scr_cs = 1'b0; expect_ok(W_SCR, 16'h5CA5);
                tick(); rom(1'b0, '0);
                tick();
                tick(); at_neg();
                check("t4_obj_resume",      32'(bus.owner),    32'(W_OBJ));
                check("t4_obj_resume_addr", 32'(bus.rom_addr), 32'h00104);
            end else begin
                tick();
            end
        end
        tick(2);

        // Test 5: rom_ok in IDLE, under the grant mask and during GAP is never forwarded.
        reset_dut();
        rom(1'b1, 16'hDEAD);
        at_neg(); check("t5_idle_ok", 32'({bus.scr_ok, bus.obj_ok}), 32'h0);
        tick(); rom(1'b0, '0); bus.obj_cs = 1'b1; bus.obj_addr = 18'h03000;
        tick(); rom(1'b1, 16'hDEAD);
        at_neg(); check("t5_masked_ok", 32'(bus.obj_ok), 32'h0);
        tick(); bus.rom_data = 16'h3333; bus.obj_cs = 1'b0; expect_ok(W_OBJ, 16'h3333);
        tick(); at_neg();
        check("t5_gap_ok",     32'({bus.scr_ok, bus.obj_ok}), 32'h0);
        check("t5_gap_rom_cs", 32'(bus.rom_cs), 32'h0);
        tick(); at_neg(); check("t5_idle2_ok", 32'({bus.scr_ok, bus.obj_ok}), 32'h0);
        tick(); rom(1'b0, '0);
        tick();

        // Reset asserted mid-grant: outputs drop at once and no ok reaches the owner.
        bus.obj_cs = 1'b1; bus.obj_addr = 18'h00077;
        tick(2);
        rst_n = 1'b0;
        rom(1'b1, 16'h7777);
        #1;
        check("rstmid_obj_ok", 32'(bus.obj_ok), 32'h0);
        check("rstmid_rom_cs", 32'(bus.rom_cs), 32'h0);
        check("rstmid_owner",  32'(bus.owner),  32'h0);
        reset_dut();

`ifdef JTCONTRA_ROM_ARB_WDOG_EN
        // Test 6: scr never receives rom_ok; watchdog releases after 16 granted cycles.
        bus.scr_cs = 1'b1; bus.scr_addr = 18'h04444;
        tick();
        tick(); bus.obj_cs = 1'b1; bus.obj_addr = 18'h05555;
        tick(14); at_neg();
        check("t6_wdog_quiet", 32'(bus.wdog_err), 32'h0);
        check("t6_scr_held",   32'(bus.owner),    32'(W_SCR));
        tick(); at_neg();
        check("t6_wdog_pulse", 32'(bus.wdog_err), 32'h1);
        check("t6_rom_cs_low", 32'(bus.rom_cs),   32'h0);
        tick(); at_neg();
        check("t6_wdog_once",  32'(bus.wdog_err), 32'h0);
        tick(); at_neg();
        check("t6_obj_grant",  32'(bus.owner),    32'(W_OBJ));
        check("t6_obj_addr",   32'(bus.rom_addr), 32'h05555);
        bus.obj_cs = 1'b0; bus.scr_cs = 1'b0;
        tick(3);
`endif

        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
